// File: rtl/gamepad_reader.sv
// Host-side SNES-style gamepad reader: drives latch/clock for one 12-bit scan
// and shifts in both pad ports in parallel, publishing active-high button words.
module gamepad_reader #(
    parameter int HALF_PERIOD = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        pad_latch,
    output logic        pad_clk,
    input  logic [1:0]  pad_data,
    output logic [11:0] p1_btn,
    output logic [11:0] p2_btn,
    output logic        valid
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LOW,
        CLK_HIGH,
        DONE
    } state_t;

    localparam logic [7:0] PHASE_LAST = 8'(HALF_PERIOD - 1);
    localparam logic [3:0] BIT_LAST   = 4'd11;

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  bit_q, bit_d;
    logic [1:0]  sync1_q, sync1_d;
    logic [1:0]  sync2_q, sync2_d;
    logic [11:0] shift_p1_q, shift_p1_d;
    logic [11:0] shift_p2_q, shift_p2_d;
    logic [11:0] p1_btn_q, p1_btn_d;
    logic [11:0] p2_btn_q, p2_btn_d;
    logic        pad_latch_q, pad_latch_d;
    logic        pad_clk_q, pad_clk_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        phase_last;

    assign phase_last = (phase_q == PHASE_LAST);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        sync1_d    = pad_data;
        sync2_d    = sync1_q;
        shift_p1_d = shift_p1_q;
        shift_p2_d = shift_p2_q;
        p1_btn_d   = p1_btn_q;
        p2_btn_d   = p2_btn_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LATCH;
                    phase_d = '0;
                    bit_d   = '0;
                end
            end
            LATCH: begin
                if (phase_last) begin
                    state_d = CLK_LOW;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            CLK_LOW: begin
                // Sample at the end of the low phase: data has had the whole
                // preceding high phase plus this one to settle through the sync.
                if (phase_last) begin
                    shift_p1_d[bit_q] = sync2_q[0];
                    shift_p2_d[bit_q] = sync2_q[1];
                    state_d           = CLK_HIGH;
                    phase_d           = '0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            CLK_HIGH: begin
                if (phase_last) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = CLK_LOW;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        pad_latch_d = (state_d == LATCH);
        pad_clk_d   = (state_d != CLK_LOW);
        busy_d      = (state_d != IDLE);
        valid_d     = (state_d == DONE);
        if (state_d == DONE) begin
            p1_btn_d = ~shift_p1_q;
            p2_btn_d = ~shift_p2_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            bit_q       <= '0;
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            shift_p1_q  <= '1;
            shift_p2_q  <= '1;
            p1_btn_q    <= '0;
            p2_btn_q    <= '0;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b1;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            shift_p1_q  <= shift_p1_d;
            shift_p2_q  <= shift_p2_d;
            p1_btn_q    <= p1_btn_d;
            p2_btn_q    <= p2_btn_d;
            pad_latch_q <= pad_latch_d;
            pad_clk_q   <= pad_clk_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
        end
    end

    assign busy      = busy_q;
    assign pad_latch = pad_latch_q;
    assign pad_clk   = pad_clk_q;
    assign p1_btn    = p1_btn_q;
    assign p2_btn    = p2_btn_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_gamepad_reader.sv
// Bench for gamepad_reader: behavioural mock pads, arithmetic timing model and
// a scoreboard of expected button words popped whenever the reader strobes valid.
module tb_gamepad_reader;

    localparam int H        = 4;
    localparam int DONE_OFF = 25 * H + 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  pad_data;
    logic        busy, pad_latch, pad_clk, valid;
    logic [11:0] p1_btn, p2_btn;

    gamepad_reader #(.HALF_PERIOD(H)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .busy     (busy),
        .pad_latch(pad_latch),
        .pad_clk  (pad_clk),
        .pad_data (pad_data),
        .p1_btn   (p1_btn),
        .p2_btn   (p2_btn),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Mock pads: latch reloads bit 0, each pad_clk rising edge advances a bit.
    logic [11:0] pad_w [2];
    bit          absent = 1'b0;
    int          idx = 12;

    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) idx <= 0;
        else           idx <= idx + 1;
    end

    always_comb begin
        pad_data = 2'b11;
        if (!absent && idx < 12) begin
            pad_data[0] = ~pad_w[0][idx[3:0]];
            pad_data[1] = ~pad_w[1][idx[3:0]];
        end
    end

    typedef struct {
        logic [11:0] p1;
        logic [11:0] p2;
        int          vcyc;
    } exp_t;

    exp_t        sb[$];
    bit          have_scan = 1'b0;
    int          sstart = 0;
    logic [11:0] cur_p1 = '0, cur_p2 = '0;
    int          checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle pin timing from the offset to the accepted start,
    // and scoreboard pop on every valid strobe.
    always @(negedge clk) begin : mon
        int   o;
        logic el, ec, eb, ev;
        exp_t e;
        if (reset_n) begin
            o  = have_scan ? cyc - sstart : -1;
            el = (o >= 1 && o <= H);
            ec = !(o >= H + 1 && o <= 25 * H && ((o - H - 1) / H) % 2 == 0);
            eb = (o >= 1 && o <= DONE_OFF);
            ev = (o == DONE_OFF);
            chk("pad_latch", 32'(pad_latch), 32'(el));
            chk("pad_clk", 32'(pad_clk), 32'(ec));
            chk("busy", 32'(busy), 32'(eb));
            chk("valid", 32'(valid), 32'(ev));
            if (valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid cyc=%0d actual=1 expected=0", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("valid_cycle", 32'(cyc), 32'(e.vcyc));
                    cur_p1 = e.p1;
                    cur_p2 = e.p2;
                end
            end
            chk("p1_btn", 32'(p1_btn), 32'(cur_p1));
            chk("p2_btn", 32'(p2_btn), 32'(cur_p2));
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start accepted only when the model says the reader is idle again.
    task automatic start_at(input int c);
        exp_t e;
        wait_cyc(c);
        start = 1'b1;
        if (!have_scan || cyc >= sstart + DONE_OFF + 1) begin
            have_scan = 1'b1;
            sstart    = cyc;
            e.p1      = absent ? 12'h000 : pad_w[0];
            e.p2      = absent ? 12'h000 : pad_w[1];
            e.vcyc    = cyc + DONE_OFF;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic scan(input logic [11:0] a, input logic [11:0] b, input bit abs);
        int s;
        pad_w[0] = a;
        pad_w[1] = b;
        absent   = abs;
        s = cyc + 2;
        start_at(s);
        wait_cyc(s + DONE_OFF + 3);
    endtask

    initial begin
        int s;
        pad_w[0] = '0;
        pad_w[1] = '0;
        #23;
        chk("rst_pad_latch", 32'(pad_latch), 32'd0);
        chk("rst_pad_clk", 32'(pad_clk), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_p1", 32'(p1_btn), 32'h000);
        chk("rst_p2", 32'(p2_btn), 32'h000);
        @(posedge clk);
        #3 reset_n = 1'b1;

        scan(12'hA5C, 12'h000, 1'b0);
        scan(12'h001, 12'h800, 1'b0);
        scan(12'h3C7, 12'h5A1, 1'b1);

        // Starts while busy and in the DONE cycle are dropped; the next one is taken.
        pad_w[0] = 12'h0F0;
        pad_w[1] = 12'h90F;
        absent   = 1'b0;
        s = cyc + 2;
        start_at(s);
        start_at(s + 50);
        start_at(s + DONE_OFF);
        start_at(s + DONE_OFF + 1);
        wait_cyc(s + 2 * DONE_OFF + 4);

        // Buttons hold after a scan even as the pad changes.
        scan(12'hFFF, 12'h123, 1'b0);
        pad_w[0] = 12'h000;
        wait_cyc(cyc + 60);

        // Reset mid-LATCH aborts the scan with no valid.
        pad_w[0] = 12'hABC;
        s = cyc + 2;
        start_at(s);
        wait_cyc(s + 2);
        #2 reset_n = 1'b0;
        have_scan = 1'b0;
        sb.delete();
        cur_p1 = '0;
        cur_p2 = '0;
        #1;
        chk("abort_pad_latch", 32'(pad_latch), 32'd0);
        chk("abort_pad_clk", 32'(pad_clk), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_p1", 32'(p1_btn), 32'h000);
        chk("abort_p2", 32'(p2_btn), 32'h000);
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        wait_cyc(cyc + 150);

        for (int i = 0; i < 10; i++) begin
            pad_w[0] = 12'($urandom);
            pad_w[1] = 12'($urandom);
            absent   = ($urandom_range(0, 7) == 0);
            s = cyc + 1 + int'($urandom_range(0, 5));
            start_at(s);
            if ($urandom_range(0, 1) == 1)
                start_at(s + int'($urandom_range(1, DONE_OFF)));
            wait_cyc(s + DONE_OFF + 2 + int'($urandom_range(0, 3)));
        end

        wait_cyc(cyc + 5);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
